param_bit_rev_stream: RTL and testbench
=======================================

Name: param_bit_rev_stream

Overview:
- Streaming, parametrised bit-permutation unit for datapaths that need bit-reversal or chunk-reversal of a message.
- Supports full bit reversal, chunk-order reversal, and bit reversal within each chunk, selected per message.
- Sits between two val/rdy interfaces with a 2-entry elastic buffer. Gives 1-cycle latency, full throughput, and no combinational rdy path from output to input.

Parameters:
- nbits, 8, message width in bits; nbits >= 2.
- group, 4, chunk width in bits; 1 <= group <= nbits and nbits % group == 0 (elaboration error otherwise).
- cnt_bits, 16, width of the transfer counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_val  input  1  input message valid.
- in_rdy  output  1  input ready.
- in_mode  input  2  transform select; sampled with in_msg.
- in_msg  input  nbits  input message.
- out_val  output  1  output message valid.
- out_rdy  input  1  downstream ready.
- out_msg  output  nbits  transformed message at head of buffer.
- xfer_count  output  cnt_bits  number of completed output transfers.

Behaviour:
- Reset: clk is the single clock; reset is asynchronous and active-high.
- Reset values, reached immediately when reset is asserted and held while it stays asserted:
  - Buffer state EMPTY, out_val=0, out_msg=0, xfer_count=0.
  - in_rdy=0 while reset is high.
  - In-flight messages are discarded.
- Input transfer: occurs when in_val && in_rdy at a rising edge.
- Output transfer: occurs when out_val && out_rdy at a rising edge.
- Transform: applied combinationally on the input side, before storage. Only transformed values are stored. Chunk k is bits [k*group+group-1 : k*group]; C = nbits/group.
  - mode 0 (PASS): out = in.
  - mode 1 (BITREV): out[i] = in[nbits-1-i] for all i.
  - mode 2 (CHUNKREV): output chunk k = input chunk C-1-k; bit order inside each chunk is unchanged.
  - mode 3 (INREV): within each chunk, bit j maps to bit group-1-j; chunk order is unchanged.
  - Identity: mode1 == mode2 applied to mode3. With group == nbits, mode2 = PASS and mode3 = BITREV. With group == 1, mode2 = BITREV and mode3 = PASS.
- Buffer FSM states: EMPTY, ONE, TWO (entry count).
  - in_rdy = (state != TWO) && !reset. in_rdy depends only on registered state.
  - out_val = (state != EMPTY). out_msg = head entry.
  - EMPTY: enqueue -> ONE.
  - ONE: enqueue only -> TWO. Dequeue only -> EMPTY. Enqueue and dequeue in the same cycle -> ONE; the new entry becomes head the next cycle.
  - TWO: dequeue -> ONE. Enqueue is impossible since in_rdy=0.
- Ordering and latency:
  - Strict FIFO order; no message is dropped or duplicated.
  - A message accepted at edge N is on out_msg with out_val=1 in cycle N+1 when the buffer was empty, or when it was in ONE with a dequeue at edge N.
- Throughput: one message per cycle sustained while out_rdy=1.
- out_msg stability: out_msg and out_val stay stable while out_val=1 and out_rdy=0.
- Don't-cares: out_msg is don't-care when out_val=0, except after reset where it is 0. in_msg and in_mode are ignored when in_val=0.
- xfer_count: increments by 1 on each output transfer and wraps modulo 2^cnt_bits (all-ones + 1 -> 0).
- Reset mid-operation: asserting reset while state is ONE or TWO clears the buffer asynchronously. After deassertion, the first accepted message is the next output.

Test Plan:
- Reset then idle: reset high mid-stream with state TWO -> out_val=0, in_rdy=0, xfer_count=0 immediately. After deassert -> in_rdy=1, out_val=0.
- Modes (nbits=8, group=4, out_rdy=1), in_msg=0xA3:
  - mode0 -> 0xA3; mode1 -> 0xC5; mode2 -> 0x3A; mode3 -> 0x5C.
  - Also in_msg=0x01 mode1 -> 0x80.
  - Each output appears 1 cycle after acceptance.
- Backpressure: out_rdy=0, send 0x11, 0x22, 0x33 in mode0 -> first two accepted, in_rdy=0 on the third and held. Raise out_rdy -> outputs 0x11, 0x22, 0x33 in order, no gaps once flowing.
- Full throughput: 16 back-to-back messages with in_val=1 and out_rdy=1 -> one output per cycle, in_rdy never deasserts, xfer_count=16 at the end.
- Simultaneous enq/deq in ONE: state ONE head=0x11, enqueue 0x22 and dequeue on the same edge -> next cycle state ONE, out_msg=0x22.
- Parametric sweep: nbits in {2, 8, 16, 32} x group in {1, 2, nbits} with random modes/messages and random val/rdy -> outputs match a software model in order; mode1 == mode2 of mode3. With cnt_bits=4, 17 transfers -> xfer_count=1.

Source files
------------

// File: rtl/param_bit_rev_stream.sv
// Streaming bit/chunk permutation unit. Up to two transformed messages are held in a
// val/rdy elastic buffer, giving 1-cycle latency and full throughput.
module param_bit_rev_stream #(
  parameter int nbits    = 8,
  parameter int group    = 4,
  parameter int cnt_bits = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_val,
  output logic                in_rdy,
  input  logic [1:0]          in_mode,
  input  logic [nbits-1:0]    in_msg,
  output logic                out_val,
  input  logic                out_rdy,
  output logic [nbits-1:0]    out_msg,
  output logic [cnt_bits-1:0] xfer_count
);

  if (nbits < 2 || group < 1 || group > nbits || (nbits % group) != 0) begin : g_bad_params
    $error("param_bit_rev_stream: need nbits >= 2, 1 <= group <= nbits, nbits %% group == 0");
  end

  localparam int nchunks = nbits / group;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  typedef enum logic [1:0] {PASS = 2'd0, BITREV = 2'd1, CHUNKREV = 2'd2, INREV = 2'd3} mode_t;

  state_t           state;
  logic [nbits-1:0] head;
  logic [nbits-1:0] tail;
  logic [nbits-1:0] bit_rev;
  logic [nbits-1:0] chunk_rev;
  logic [nbits-1:0] in_rev;
  logic [nbits-1:0] xformed;
  logic             enq;
  logic             deq;

  // The transform sits on the input side so only finished values are stored.
  always_comb begin
    bit_rev   = '0;
    chunk_rev = '0;
    in_rev    = '0;
    xformed   = in_msg;
    for (int i = 0; i < nbits; i++) begin
      bit_rev[i] = in_msg[nbits-1-i];
    end
    for (int k = 0; k < nchunks; k++) begin
      for (int j = 0; j < group; j++) begin
        chunk_rev[k*group+j] = in_msg[(nchunks-1-k)*group+j];
        in_rev[k*group+j]    = in_msg[k*group+group-1-j];
      end
    end
    case (mode_t'(in_mode))
      PASS:     xformed = in_msg;
      BITREV:   xformed = bit_rev;
      CHUNKREV: xformed = chunk_rev;
      INREV:    xformed = in_rev;
      default:  xformed = in_msg;
    endcase
  end

  // Ready looks only at registered state, so no combinational path from out_rdy to in_rdy.
  assign in_rdy  = (state != TWO) && !reset;
  assign enq     = in_val && in_rdy;
  assign deq     = out_val && out_rdy;
  assign out_msg = head;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= EMPTY;
      out_val    <= 1'b0;
      xfer_count <= '0;
      // NOTE: the two entries are cleared because out_msg must read 0 after reset;
      // a deeper buffer would normally be left unreset.
      head       <= '0;
      tail       <= '0;
    end else begin
      if (deq) begin
        xfer_count <= xfer_count + cnt_bits'(1);
      end
      case (state)
        EMPTY: begin
          if (enq) begin
            head    <= xformed;
            out_val <= 1'b1;
            state   <= ONE;
          end
        end
        ONE: begin
          if (enq && deq) begin
            head <= xformed;
          end else if (enq) begin
            tail  <= xformed;
            state <= TWO;
          end else if (deq) begin
            out_val <= 1'b0;
            state   <= EMPTY;
          end
        end
        TWO: begin
          if (deq) begin
            head  <= tail;
            state <= ONE;
          end
        end
        default: begin
          out_val <= 1'b0;
          state   <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_bit_rev_stream.sv
// Scoreboard bench for param_bit_rev_stream: directed and random traffic on an 8/4 instance,
// plus a sweep of nbits x group instances with a 4-bit transfer counter.
module tb_param_bit_rev_stream;

  logic       clk;
  logic       reset    = 1'b1;
  logic       sw_reset = 1'b1;
  logic       in_val;
  logic       in_rdy;
  logic [1:0] in_mode;
  logic [7:0] in_msg;
  logic       out_val;
  logic       out_rdy;
  logic [7:0] out_msg;
  logic [15:0] xfer_count;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int sweep_finished = 0;

  typedef struct {
    logic [7:0] msg;
    int         acc;
    bit         lat;
  } exp_t;
  exp_t exp_q[$];

  param_bit_rev_stream #(.nbits(8), .group(4), .cnt_bits(16)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .in_val     (in_val),
    .in_rdy     (in_rdy),
    .in_mode    (in_mode),
    .in_msg     (in_msg),
    .out_val    (out_val),
    .out_rdy    (out_rdy),
    .out_msg    (out_msg),
    .xfer_count (xfer_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: reverse a w-bit value by shifting bits out one end and in the other.
  function automatic logic [31:0] rev_val(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      r = (r << 1) | (v & 32'd1);
      v = v >> 1;
    end
    return r;
  endfunction

  // Reference model: split the message into chunk values, then reorder or reverse them.
  function automatic logic [31:0] ref_xform(input logic [31:0] m, input logic [1:0] md,
                                            input int n, input int g);
    logic [31:0] chunks[$];
    logic [31:0] r;
    logic [31:0] mask;
    int          c;
    c    = n / g;
    mask = (g >= 32) ? '1 : ((32'd1 << g) - 32'd1);
    if (n < 32) m = m & ((32'd1 << n) - 32'd1);
    for (int k = 0; k < c; k++) chunks.push_back((m >> (k * g)) & mask);
    r = '0;
    case (md)
      2'd0: r = m;
      2'd1: r = rev_val(m, n);
      2'd2: for (int k = 0; k < c; k++) r = r | (chunks[c-1-k] << (k * g));
      default: for (int k = 0; k < c; k++) r = r | (rev_val(chunks[k], g) << (k * g));
    endcase
    return r;
  endfunction

  // Entered and left just after a rising edge; holds the message until it is accepted.
  task automatic send(input logic [7:0] m, input logic [1:0] md, input logic [7:0] e,
                      input bit lat, output int waits);
    exp_t x;
    in_val  = 1'b1;
    in_msg  = m;
    in_mode = md;
    waits   = 0;
    @(negedge clk);
    while (!in_rdy && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    if (!in_rdy) begin
      check("send_timeout", 64'd0, 64'd1);
    end else begin
      x.msg = e;
      x.acc = cyc + 1;
      x.lat = lat;
      exp_q.push_back(x);
    end
    @(posedge clk);
    #1;
    in_val = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    out_rdy = 1'b1;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Main scoreboard monitor: one pop per output transfer.
  always @(negedge clk) begin
    if (out_val && out_rdy) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'(out_msg), 64'hx);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_msg", 64'(out_msg), 64'(e.msg));
        if (e.lat) check("latency", 64'(cyc), 64'(e.acc));
      end
    end
  end

  initial begin
    int w;
    int stalls;
    bit prod_done;
    logic [7:0] m;
    logic [1:0] md;
    logic [7:0] dir_in [5]  = '{8'hA3, 8'hA3, 8'hA3, 8'hA3, 8'h01};
    logic [1:0] dir_md [5]  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
    logic [7:0] dir_exp [5] = '{8'hA3, 8'hC5, 8'h3A, 8'h5C, 8'h80};

    in_val  = 1'b0;
    in_mode = 2'd0;
    in_msg  = 8'h00;
    out_rdy = 1'b0;

    #1;
    check("rst_out_val", 64'(out_val), 64'd0);
    check("rst_in_rdy", 64'(in_rdy), 64'd0);
    check("rst_out_msg", 64'(out_msg), 64'd0);
    check("rst_xfer", 64'(xfer_count), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
    sw_reset = 1'b0;
    @(negedge clk);
    check("idle_in_rdy", 64'(in_rdy), 64'd1);
    check("idle_out_val", 64'(out_val), 64'd0);
    @(posedge clk);
    #1;

    // Transform modes, each from an empty buffer.
    out_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(dir_in[i], dir_md[i], dir_exp[i], 1'b1, w);
      @(posedge clk);
      #1;
    end
    drain();

    // Backpressure: two accepted, third held off until the sink drains.
    out_rdy = 1'b0;
    send(8'h11, 2'd0, 8'h11, 1'b0, w);
    send(8'h22, 2'd0, 8'h22, 1'b0, w);
    in_val  = 1'b1;
    in_msg  = 8'h33;
    in_mode = 2'd0;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_rdy_low", 64'(in_rdy), 64'd0);
      check("bp_out_val", 64'(out_val), 64'd1);
      check("bp_hold_msg", 64'(out_msg), 64'h11);
    end
    @(posedge clk);
    #1;
    out_rdy = 1'b1;
    fork
      send(8'h33, 2'd0, 8'h33, 1'b0, w);
      begin
        repeat (3) begin
          @(negedge clk);
          check("bp_no_gap", 64'(out_val), 64'd1);
        end
      end
    join
    drain();

    // Enqueue and dequeue on the same edge while holding one entry.
    out_rdy = 1'b0;
    send(8'h11, 2'd0, 8'h11, 1'b0, w);
    out_rdy = 1'b1;
    send(8'h22, 2'd0, 8'h22, 1'b1, w);
    @(negedge clk);
    check("sim_out_msg", 64'(out_msg), 64'h22);
    check("sim_out_val", 64'(out_val), 64'd1);
    check("sim_one_in_rdy", 64'(in_rdy), 64'd1);
    drain();

    // Reset mid-stream with the buffer full.
    out_rdy = 1'b0;
    send(8'h55, 2'd0, 8'h55, 1'b0, w);
    send(8'h66, 2'd0, 8'h66, 1'b0, w);
    @(negedge clk);
    check("full_in_rdy", 64'(in_rdy), 64'd0);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_out_val", 64'(out_val), 64'd0);
    check("mid_rst_in_rdy", 64'(in_rdy), 64'd0);
    check("mid_rst_xfer", 64'(xfer_count), 64'd0);
    check("mid_rst_out_msg", 64'(out_msg), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_rdy", 64'(in_rdy), 64'd1);
    check("post_rst_out_val", 64'(out_val), 64'd0);
    @(posedge clk);
    #1;

    // Full throughput: 16 back-to-back messages, never stalled.
    out_rdy = 1'b1;
    stalls  = 0;
    for (int i = 0; i < 16; i++) begin
      m  = 8'($urandom);
      md = 2'($urandom);
      send(m, md, 8'(ref_xform(32'(m), md, 8, 4)), 1'b1, w);
      stalls += w;
    end
    check("thru_stalls", 64'(stalls), 64'd0);
    drain();
    check("thru_xfer", 64'(xfer_count), 64'd16);

    // Random traffic with random backpressure.
    prod_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          repeat ($urandom_range(0, 1)) begin
            @(posedge clk);
            #1;
          end
          m  = 8'($urandom);
          md = 2'($urandom);
          send(m, md, 8'(ref_xform(32'(m), md, 8, 4)), 1'b0, w);
        end
        prod_done = 1'b1;
      end
      begin
        while (!prod_done) begin
          @(posedge clk);
          #1;
          out_rdy = ($urandom_range(0, 2) != 0);
        end
      end
    join
    drain();
    check("rand_xfer", 64'(xfer_count), 64'd166);

    for (int t = 0; t < 5000 && sweep_finished < 12; t++) @(posedge clk);
    check("sweep_complete", 64'(sweep_finished), 64'd12);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Parameter sweep: nbits in {2,8,16,32} x group in {1,2,nbits}, 17 transfers each.
  for (genvar a = 0; a < 4; a++) begin : g_nb
    for (genvar b = 0; b < 3; b++) begin : g_gr
      localparam int N = (a == 0) ? 2 : (4 << a);
      localparam int G = (b == 0) ? 1 : ((b == 1) ? 2 : N);

      logic         s_in_val;
      logic         s_in_rdy;
      logic [1:0]   s_mode;
      logic [N-1:0] s_msg;
      logic         s_out_val;
      logic         s_out_rdy;
      logic [N-1:0] s_out;
      logic [3:0]   s_cnt;
      logic [N-1:0] s_q[$];
      int           s_sent;
      int           s_got;

      param_bit_rev_stream #(.nbits(N), .group(G), .cnt_bits(4)) u_sweep (
        .clk        (clk),
        .reset      (sw_reset),
        .in_val     (s_in_val),
        .in_rdy     (s_in_rdy),
        .in_mode    (s_mode),
        .in_msg     (s_msg),
        .out_val    (s_out_val),
        .out_rdy    (s_out_rdy),
        .out_msg    (s_out),
        .xfer_count (s_cnt)
      );

      initial begin
        s_in_val  = 1'b0;
        s_mode    = 2'd0;
        s_msg     = '0;
        s_out_rdy = 1'b0;
        s_sent    = 0;
        s_got     = 0;
        wait (sw_reset == 1'b0);
        while (s_sent < 17) begin
          @(posedge clk);
          #1;
          s_in_val  = ($urandom_range(0, 3) != 0);
          s_msg     = N'($urandom);
          s_mode    = 2'($urandom);
          s_out_rdy = ($urandom_range(0, 2) != 0);
          @(negedge clk);
          if (s_in_val && s_in_rdy) begin
            s_q.push_back(N'(ref_xform(32'(s_msg), s_mode, N, G)));
            s_sent++;
          end
        end
        @(posedge clk);
        #1;
        s_in_val = 1'b0;
        while (s_got < 17) begin
          @(posedge clk);
          #1;
          s_out_rdy = ($urandom_range(0, 2) != 0);
        end
        check($sformatf("sweep_n%0d_g%0d_xfer", N, G), 64'(s_cnt), 64'd1);
        sweep_finished++;
      end

      always @(negedge clk) begin
        if (!sw_reset && s_out_val && s_out_rdy) begin
          if (s_q.size() == 0) begin
            check($sformatf("sweep_n%0d_g%0d_extra", N, G), 64'(s_out), 64'hx);
          end else begin
            check($sformatf("sweep_n%0d_g%0d_msg", N, G), 64'(s_out), 64'(s_q.pop_front()));
            s_got++;
          end
        end
      end
    end
  end

endmodule
